// File: rtl/nx_fifo_rr_wr_arb.sv
// nx_fifo_rr_wr_arb: round-robin, packet-locking arbiter for one FIFO write port
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/last/data  per-requester beat valid, last-beat flag, data at [i*DW +: DW]
//   req_ready            per-requester accept (at most one bit high)
//   clear                synchronous flush of arbiter state
//   fifo_full/free_slots FIFO status used for flow control
//   fifo_wen/wdata       registered FIFO write stage
//   grant_id, locked     current or most recent owner, packet in progress
//   burst_err            sticky: a packet exceeded MAX_BURST beats
module nx_fifo_rr_wr_arb #(
    parameter int N_REQ     = 4,
    parameter int DW        = 83,
    parameter int CW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    input  logic [N_REQ*DW-1:0]        req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       clear,
    input  logic                       fifo_full,
    input  logic [CW-1:0]              fifo_free_slots,
    output logic                       fifo_wen,
    output logic [DW-1:0]              fifo_wdata,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       locked,
    output logic                       burst_err
);
    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 2);

    logic [N_REQ-1:0][DW-1:0] req_arr;
    logic                     armed_q, locked_q, locked_d, burst_err_q, burst_err_d;
    logic                     fifo_wen_q, fifo_wen_d;
    logic [DW-1:0]            fifo_wdata_q, fifo_wdata_d;
    logic [IW-1:0]            grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]            win, acc_id, acc_nxt;
    logic [BW-1:0]            cnt_q, cnt_d;
    logic                     found, space_ok, accept, acc_last;

    assign req_arr = req_data;
    // The beat already sitting in the write register will occupy one slot.
    assign space_ok = !fifo_full && (fifo_free_slots > CW'(fifo_wen_q));

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[IW'((int'(rr_ptr_q) + k) % N_REQ)]) begin
                win   = IW'((int'(rr_ptr_q) + k) % N_REQ);
                found = 1'b1;
            end
        end
    end

    // grant_id_q doubles as the packet owner while locked.
    always_comb begin
        req_ready = '0;
        if (armed_q && !clear) begin
            if (locked_q)
                req_ready[grant_id_q] = req_valid[grant_id_q] & space_ok;
            else if (found)
                req_ready[win] = space_ok;
        end
    end

    assign acc_id   = locked_q ? grant_id_q : win;
    assign accept   = |(req_valid & req_ready);
    assign acc_last = req_last[acc_id];
    assign acc_nxt  = (acc_id == IW'(N_REQ - 1)) ? '0 : acc_id + 1'b1;

    always_comb begin
        locked_d     = locked_q;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        burst_err_d  = burst_err_q;
        fifo_wen_d   = accept;
        fifo_wdata_d = accept ? req_arr[acc_id] : fifo_wdata_q;
        if (clear) begin
            locked_d    = 1'b0;
            grant_id_d  = '0;
            rr_ptr_d    = '0;
            cnt_d       = '0;
            burst_err_d = 1'b0;
            fifo_wen_d  = 1'b0;
        end else if (accept) begin
            grant_id_d = acc_id;
            if (locked_q) begin
                // Saturate at MAX_BURST+1; the overlong packet still completes.
                cnt_d = (cnt_q > BW'(MAX_BURST)) ? cnt_q : cnt_q + 1'b1;
                if (cnt_q >= BW'(MAX_BURST))
                    burst_err_d = 1'b1;
            end else begin
                cnt_d = BW'(1);
            end
            if (acc_last) begin
                locked_d = 1'b0;
                rr_ptr_d = acc_nxt;
                cnt_d    = '0;
            end else begin
                locked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q      <= 1'b0;
            locked_q     <= 1'b0;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            burst_err_q  <= 1'b0;
            fifo_wen_q   <= 1'b0;
            fifo_wdata_q <= '0;
        end else begin
            armed_q      <= 1'b1;
            locked_q     <= locked_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            burst_err_q  <= burst_err_d;
            fifo_wen_q   <= fifo_wen_d;
            fifo_wdata_q <= fifo_wdata_d;
        end
    end

    assign fifo_wen   = fifo_wen_q;
    assign fifo_wdata = fifo_wdata_q;
    assign grant_id   = grant_id_q;
    assign locked     = locked_q;
    assign burst_err  = burst_err_q;
endmodule

// File: tb/tb_nx_fifo_rr_wr_arb.sv
// tb_nx_fifo_rr_wr_arb: directed scoreboard bench for nx_fifo_rr_wr_arb
module tb_nx_fifo_rr_wr_arb;
    localparam int DW = 83;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [3:0]          v = '0, l = '0, req_ready;
    logic [3:0][DW-1:0]  dat;
    logic                clear = 1'b0, full = 1'b0;
    logic [7:0]          free = 8'd200;
    logic                fifo_wen, locked, burst_err;
    logic [DW-1:0]       fifo_wdata, last_wdata = '0;
    logic [1:0]          grant_id;
    logic [DW-1:0]       sb[$];
    int                  checks = 0, fails = 0;

    always #5 clk = ~clk;

    nx_fifo_rr_wr_arb dut (
        .clk(clk), .rst_n(rst_n), .req_valid(v), .req_last(l), .req_data(dat),
        .req_ready(req_ready), .clear(clear), .fifo_full(full), .fifo_free_slots(free),
        .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .grant_id(grant_id),
        .locked(locked), .burst_err(burst_err)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_data();
        for (int i = 0; i < 4; i++)
            dat[i] = DW'({$urandom(), $urandom(), $urandom()});
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic step(input logic [3:0] er, input logic [1:0] eg, input logic el, input logic ee);
        logic [DW-1:0] e;
        #1;
        chk("req_ready", DW'(req_ready), DW'(er));
        for (int i = 0; i < 4; i++)
            if (er[i] && v[i]) sb.push_back(dat[i]);
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("fifo_wen", DW'(fifo_wen), DW'(1'b1));
            chk("fifo_wdata", fifo_wdata, e);
            last_wdata = e;
        end else begin
            chk("fifo_wen_idle", DW'(fifo_wen), DW'(1'b0));
            chk("wdata_hold", fifo_wdata, last_wdata);
        end
        chk("grant_id", DW'(grant_id), DW'(eg));
        chk("locked", DW'(locked), DW'(el));
        chk("burst_err", DW'(burst_err), DW'(ee));
        @(negedge clk);
        new_data();
    endtask

    task automatic reset_checks();
        chk("rst_wen", DW'(fifo_wen), DW'(1'b0));
        chk("rst_wdata", fifo_wdata, '0);
        chk("rst_grant", DW'(grant_id), DW'(2'd0));
        chk("rst_locked", DW'(locked), DW'(1'b0));
        chk("rst_err", DW'(burst_err), DW'(1'b0));
        chk("rst_ready", DW'(req_ready), DW'(4'b0000));
    endtask

    initial begin
        new_data();
        v = 4'b1111;
        l = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;
        // first edge after release: not armed yet
        step(4'b0000, 2'd0, 1'b0, 1'b0);
        // fairness: single beats from everyone
        for (int k = 0; k < 8; k++)
            step(4'b0001 << (k % 4), 2'(k % 4), 1'b0, 1'b0);
        // packet lock: req0 3-beat packet against req1 single beats
        v = 4'b0011; l = 4'b0010;
        step(4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 2'd0, 1'b1, 1'b0);
        l = 4'b0011;
        step(4'b0001, 2'd0, 1'b0, 1'b0);
        v = 4'b0010;
        step(4'b0010, 2'd1, 1'b0, 1'b0);
        // space limit: one free slot, in-flight write consumes it
        free = 8'd1; v = 4'b0001; l = 4'b0001;
        step(4'b0000, 2'd1, 1'b0, 1'b0);
        step(4'b0001, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0001, 2'd0, 1'b0, 1'b0);
        free = 8'd0;
        step(4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0000, 2'd0, 1'b0, 1'b0);
        free = 8'd200; full = 1'b1;
        step(4'b0000, 2'd0, 1'b0, 1'b0);
        full = 1'b0;
        // burst error: req2 sends 17 beats, with an owner-idle stall inside
        v = 4'b0100; l = 4'b0000;
        for (int b = 1; b <= 16; b++) begin
            if (b == 6) begin
                v = 4'b0001;
                step(4'b0000, 2'd2, 1'b1, 1'b0);
                v = 4'b0100;
            end
            step(4'b0100, 2'd2, 1'b1, 1'b0);
        end
        l = 4'b0100;
        step(4'b0100, 2'd2, 1'b0, 1'b1);
        v = 4'b1000; l = 4'b1000;
        step(4'b1000, 2'd3, 1'b0, 1'b1);
        // clear mid-packet
        v = 4'b0010; l = 4'b0000;
        step(4'b0010, 2'd1, 1'b1, 1'b1);
        step(4'b0010, 2'd1, 1'b1, 1'b1);
        clear = 1'b1; v = 4'b0011;
        step(4'b0000, 2'd0, 1'b0, 1'b0);
        clear = 1'b0; l = 4'b0011;
        step(4'b0001, 2'd0, 1'b0, 1'b0);
        v = 4'b0010;
        step(4'b0010, 2'd1, 1'b0, 1'b0);
        // reset mid-packet
        v = 4'b0001; l = 4'b0000;
        step(4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0001, 2'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        reset_checks();
        @(posedge clk);
        #1;
        chk("rst_hold_wen", DW'(fifo_wen), DW'(1'b0));
        chk("rst_hold_ready", DW'(req_ready), DW'(4'b0000));
        @(negedge clk);
        rst_n = 1'b1;
        last_wdata = '0;
        step(4'b0000, 2'd0, 1'b0, 1'b0);
        v = 4'b0011; l = 4'b0011;
        step(4'b0001, 2'd0, 1'b0, 1'b0);
        step(4'b0010, 2'd1, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
